// File: rtl/efuse_cfg_loader.sv
// rtl/efuse_cfg_loader.sv - boot-time efuse reader that serializes bytes MSB-first into the config chain
// Optional trailing CRC-8 check of the image: define EFUSE_CFG_LOADER_CRC_EN.

module efuse_cfg_loader #(
    parameter logic [10:0] START_ADDR  = 11'd0,
    parameter int          NUM_BYTES   = 256,
    parameter int          ACK_TIMEOUT = 63
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    output logic        m_wb_we_o,
    output logic        m_wb_sel_o,
    output logic [10:0] m_wb_adr_o,
    input  logic [7:0]  m_wb_dat_i,
    input  logic        m_wb_ack_i,
    input  logic        cfg_ready_i,
    output logic        cfg_data_o,
    output logic        cfg_shift_o
);

    localparam int            TW       = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);
    localparam logic [11:0]   LAST_IDX = 12'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_SHIFT,
        S_FINISH
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [11:0]   r_count;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bitcnt;
    logic          r_done;
    logic          r_error;

    logic          w_in_read;
    logic          w_in_shift;
    logic          w_bit_ok;
    logic [10:0]   w_adr;

    assign w_in_read  = (r_state == S_READ);
    assign w_in_shift = (r_state == S_SHIFT);
    assign w_bit_ok   = w_in_shift && cfg_ready_i;
    assign w_adr      = START_ADDR + r_count[10:0];

`ifdef EFUSE_CFG_LOADER_CRC_EN
    localparam logic [11:0] CRC_IDX = 12'(NUM_BYTES);

    logic [7:0] r_crc;
    logic       w_crc_rd;
    logic       w_crc_bad;

    // The read at index NUM_BYTES returns the stored checksum, not image data.
    assign w_crc_rd  = (r_count == CRC_IDX);
    assign w_crc_bad = (m_wb_dat_i != r_crc);

    function automatic logic [7:0] f_crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                // Ack wins over a timeout landing on the same cycle.
                if (m_wb_ack_i) begin
`ifdef EFUSE_CFG_LOADER_CRC_EN
                    if (w_crc_rd) begin
                        w_next = w_crc_bad ? S_IDLE : S_FINISH;
                    end else begin
                        w_next = S_SHIFT;
                    end
`else
                    w_next = S_SHIFT;
`endif
                end else if (r_tmo == TMO_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (w_bit_ok && (r_bitcnt == 3'd0)) begin
`ifdef EFUSE_CFG_LOADER_CRC_EN
                    w_next = S_READ;
`else
                    w_next = (r_count == LAST_IDX) ? S_FINISH : S_READ;
`endif
                end
            end
            S_FINISH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_o      = (r_state != S_IDLE);
        m_wb_cyc_o  = w_in_read;
        m_wb_stb_o  = w_in_read;
        m_wb_we_o   = 1'b0;
        m_wb_sel_o  = 1'b1;
        m_wb_adr_o  = w_in_read ? w_adr : 11'd0;
        cfg_data_o  = w_in_shift && r_shreg[7];
        cfg_shift_o = w_bit_ok;
    end

    assign done_o  = r_done;
    assign error_o = r_error;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_count  <= '0;
            r_tmo    <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_done   <= 1'b0;
            r_error  <= 1'b0;
`ifdef EFUSE_CFG_LOADER_CRC_EN
            r_crc    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_count <= '0;
                        r_tmo   <= '0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
`ifdef EFUSE_CFG_LOADER_CRC_EN
                        r_crc   <= '0;
`endif
                    end
                end
                S_READ: begin
                    if (m_wb_ack_i) begin
                        r_tmo <= '0;
`ifdef EFUSE_CFG_LOADER_CRC_EN
                        if (w_crc_rd) begin
                            if (w_crc_bad) begin
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_shreg  <= m_wb_dat_i;
                            r_bitcnt <= 3'd7;
                            r_crc    <= f_crc8(r_crc, m_wb_dat_i);
                        end
`else
                        r_shreg  <= m_wb_dat_i;
                        r_bitcnt <= 3'd7;
`endif
                    end else if (r_tmo == TMO_LAST) begin
                        r_tmo   <= '0;
                        r_error <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_bit_ok) begin
                        r_shreg  <= {r_shreg[6:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 3'd1;
                        if (r_bitcnt == 3'd0) begin
                            r_count <= r_count + 12'd1;
                        end
                    end
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_efuse_cfg_loader.sv
// tb/tb_efuse_cfg_loader.sv - directed self-checking bench for efuse_cfg_loader

module tb_efuse_cfg_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

`ifdef EFUSE_CFG_LOADER_CRC_EN
    localparam int A_READS  = 3;
    localparam int A_DONE_N = 21;
`else
    localparam int A_READS  = 2;
    localparam int A_DONE_N = 20;
`endif

    logic [7:0] mem [0:2047];

    logic        a_start, a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_sel;
    logic [10:0] a_adr;
    logic [7:0]  a_dat;
    logic        a_ack, a_ready, a_cfg_data, a_cfg_shift;
    int          a_delay;
    bit          a_noack;
    int          a_wcnt;

    logic        b_start, b_busy, b_done, b_error, b_cyc, b_stb, b_we, b_sel;
    logic [10:0] b_adr;
    logic [7:0]  b_dat;
    logic        b_ack, b_ready, b_cfg_data, b_cfg_shift;

    assign a_dat = mem[a_adr];
    assign a_ack = a_stb && !a_noack && (a_wcnt >= a_delay);
    always @(posedge clk) begin
        if (a_stb && !a_ack) a_wcnt <= a_wcnt + 1;
        else                 a_wcnt <= 0;
    end

    assign b_dat = mem[b_adr];
    assign b_ack = b_stb;

    efuse_cfg_loader #(.START_ADDR(11'h010), .NUM_BYTES(2), .ACK_TIMEOUT(63)) u_dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(a_start),
        .busy_o(a_busy), .done_o(a_done), .error_o(a_error),
        .m_wb_cyc_o(a_cyc), .m_wb_stb_o(a_stb), .m_wb_we_o(a_we), .m_wb_sel_o(a_sel),
        .m_wb_adr_o(a_adr), .m_wb_dat_i(a_dat), .m_wb_ack_i(a_ack),
        .cfg_ready_i(a_ready), .cfg_data_o(a_cfg_data), .cfg_shift_o(a_cfg_shift)
    );

    efuse_cfg_loader #(.START_ADDR(11'h020), .NUM_BYTES(4), .ACK_TIMEOUT(63)) u_dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(b_start),
        .busy_o(b_busy), .done_o(b_done), .error_o(b_error),
        .m_wb_cyc_o(b_cyc), .m_wb_stb_o(b_stb), .m_wb_we_o(b_we), .m_wb_sel_o(b_sel),
        .m_wb_adr_o(b_adr), .m_wb_dat_i(b_dat), .m_wb_ack_i(b_ack),
        .cfg_ready_i(b_ready), .cfg_data_o(b_cfg_data), .cfg_shift_o(b_cfg_shift)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic        obs_bits [$];
    logic [10:0] obs_addrs [$];
    int          obs_stb, obs_end, obs_shifts, obs_unready, obs_stall_bad;
    bit          obs_timeout;
    logic        obs_done, obs_error, obs_cyc;

`ifdef EFUSE_CFG_LOADER_CRC_EN
    function automatic logic [7:0] tb_crc8(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction
`endif

    task automatic set_a_mem(input logic [7:0] b0, input logic [7:0] b1);
        mem[11'h010] = b0;
        mem[11'h011] = b1;
`ifdef EFUSE_CFG_LOADER_CRC_EN
        mem[11'h012] = tb_crc8(tb_crc8(8'h00, b0), b1);
`endif
    endtask

    function automatic logic [15:0] bits16();
        logic [15:0] v;
        v = '0;
        foreach (obs_bits[i]) v = {v[14:0], obs_bits[i]};
        return v;
    endfunction

    // Pulses start on instance A and records bus/chain activity until it returns to idle.
    task automatic run_a(input int max_cyc, input bit toggle);
        obs_bits.delete();
        obs_addrs.delete();
        obs_stb = 0; obs_end = -1; obs_shifts = 0; obs_unready = 0; obs_stall_bad = 0;
        obs_timeout = 1'b1; obs_done = 1'bx; obs_error = 1'bx; obs_cyc = 1'bx;
        @(posedge clk); #1 a_start = 1'b1;
        @(posedge clk); #1 a_start = 1'b0;
        for (int n = 1; n <= max_cyc; n++) begin
            if (toggle) a_ready = ~a_ready;
            @(negedge clk);
            if (a_stb) obs_stb++;
            if (a_stb && a_ack) obs_addrs.push_back(a_adr);
            if (toggle && !a_stb && a_busy && obs_shifts < 8 && a_cfg_data !== 1'b1) obs_stall_bad++;
            if (a_cfg_shift) begin
                obs_bits.push_back(a_cfg_data);
                obs_shifts++;
                if (!a_ready) obs_unready++;
            end
            if (!a_busy) begin
                obs_end = n; obs_done = a_done; obs_error = a_error; obs_cyc = a_cyc | a_stb;
                obs_timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        a_ready = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        vec_cnt++;
        if ({a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_sel, a_cfg_data, a_cfg_shift} !== 9'b000000100) begin
            err_cnt++;
            $display("FAIL reset_outputs: got %b expected %b",
                     {a_busy, a_done, a_error, a_cyc, a_stb, a_we, a_sel, a_cfg_data, a_cfg_shift}, 9'b000000100);
        end
        vec_cnt++;
        if (a_adr !== 11'h000) begin
            err_cnt++; $display("FAIL reset_adr: got %h expected 000", a_adr);
        end
        #10 rst = 1'b0;
    endtask

    task automatic test_basic();
        set_a_mem(8'hA5, 8'h3C);
        a_delay = 0;
        run_a(100, 1'b0);
        vec_cnt++;
        if (obs_timeout) begin err_cnt++; $display("FAIL basic_finish: got timeout expected idle"); end
        vec_cnt++;
        if (obs_end != A_DONE_N) begin err_cnt++; $display("FAIL basic_done_cycle: got %0d expected %0d", obs_end, A_DONE_N); end
        vec_cnt++;
        if ({obs_done, obs_error} !== 2'b10) begin err_cnt++; $display("FAIL basic_status: got %b expected 10", {obs_done, obs_error}); end
        vec_cnt++;
        if (obs_addrs.size() != A_READS) begin
            err_cnt++; $display("FAIL basic_read_count: got %0d expected %0d", obs_addrs.size(), A_READS);
        end else if (obs_addrs[0] !== 11'h010 || obs_addrs[1] !== 11'h011) begin
            err_cnt++; $display("FAIL basic_addrs: got %h %h expected 010 011", obs_addrs[0], obs_addrs[1]);
        end
`ifdef EFUSE_CFG_LOADER_CRC_EN
        else if (obs_addrs[2] !== 11'h012) begin
            err_cnt++; $display("FAIL basic_crc_addr: got %h expected 012", obs_addrs[2]);
        end
`endif
        vec_cnt++;
        if (obs_shifts != 16 || bits16() !== 16'b1010_0101_0011_1100) begin
            err_cnt++; $display("FAIL basic_bits: got %0d bits %h expected 16 bits a53c", obs_shifts, bits16());
        end
    endtask

    task automatic test_ack_delay();
        set_a_mem(8'h5A, 8'hC3);
        a_delay = 5;
        run_a(200, 1'b0);
        vec_cnt++;
        if (obs_stb != 6 * A_READS) begin err_cnt++; $display("FAIL delay_stb_cycles: got %0d expected %0d", obs_stb, 6 * A_READS); end
        vec_cnt++;
        if (bits16() !== 16'h5AC3) begin err_cnt++; $display("FAIL delay_bits: got %h expected 5ac3", bits16()); end
        vec_cnt++;
        if (obs_timeout || {obs_done, obs_error} !== 2'b10) begin
            err_cnt++; $display("FAIL delay_status: got %b expected 10", {obs_done, obs_error});
        end
        a_delay = 0;
    endtask

    task automatic test_ack_at_timeout();
        set_a_mem(8'h81, 8'h7E);
        a_delay = 62;
        run_a(400, 1'b0);
        vec_cnt++;
        if (obs_timeout || {obs_done, obs_error} !== 2'b10) begin
            err_cnt++; $display("FAIL ack_edge_status: got %b expected 10", {obs_done, obs_error});
        end
        vec_cnt++;
        if (obs_stb != 63 * A_READS || bits16() !== 16'h817E) begin
            err_cnt++; $display("FAIL ack_edge_data: got stb %0d bits %h expected stb %0d bits 817e", obs_stb, bits16(), 63 * A_READS);
        end
        a_delay = 0;
    endtask

    task automatic test_timeout();
        a_noack = 1'b1;
        run_a(200, 1'b0);
        vec_cnt++;
        if (obs_timeout || obs_stb != 63) begin err_cnt++; $display("FAIL timeout_stb_cycles: got %0d expected 63", obs_stb); end
        vec_cnt++;
        if (obs_end != 64) begin err_cnt++; $display("FAIL timeout_busy_fall: got %0d expected 64", obs_end); end
        vec_cnt++;
        if ({obs_done, obs_error, obs_cyc} !== 3'b010) begin
            err_cnt++; $display("FAIL timeout_status: got %b expected 010", {obs_done, obs_error, obs_cyc});
        end
        vec_cnt++;
        if (obs_shifts != 0) begin err_cnt++; $display("FAIL timeout_no_shift: got %0d expected 0", obs_shifts); end
        a_noack = 1'b0;
    endtask

    task automatic test_ready_stall();
        set_a_mem(8'hFF, 8'h00);
        run_a(200, 1'b1);
        vec_cnt++;
        if (obs_shifts != 16 || bits16() !== 16'hFF00) begin
            err_cnt++; $display("FAIL stall_bits: got %0d bits %h expected 16 bits ff00", obs_shifts, bits16());
        end
        vec_cnt++;
        if (obs_unready != 0) begin err_cnt++; $display("FAIL stall_shift_unready: got %0d expected 0", obs_unready); end
        vec_cnt++;
        if (obs_stall_bad != 0) begin err_cnt++; $display("FAIL stall_data_hold: got %0d expected 0", obs_stall_bad); end
        vec_cnt++;
        if (obs_timeout || {obs_done, obs_error} !== 2'b10) begin
            err_cnt++; $display("FAIL stall_status: got %b expected 10", {obs_done, obs_error});
        end
    endtask

    task automatic test_reset_midshift();
        int   cnt;
        bit   hit;
        logic [7:0] first;
        bit   fin;
        mem[11'h020] = 8'h11; mem[11'h021] = 8'h22; mem[11'h022] = 8'h33; mem[11'h023] = 8'h44;
`ifdef EFUSE_CFG_LOADER_CRC_EN
        mem[11'h024] = tb_crc8(tb_crc8(tb_crc8(tb_crc8(8'h00, 8'h11), 8'h22), 8'h33), 8'h44);
`endif
        b_ready = 1'b1;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        cnt = 0; hit = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (b_cfg_shift) cnt++;
            if (cnt == 19) begin hit = 1'b1; break; end
            @(posedge clk);
        end
        vec_cnt++;
        if (!hit || b_cfg_data !== 1'b1) begin
            err_cnt++; $display("FAIL rst_reach_byte3: got shifts %0d data %b expected 19 and 1", cnt, b_cfg_data);
        end
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({b_busy, b_done, b_error, b_cyc, b_stb, b_we, b_sel, b_cfg_data, b_cfg_shift} !== 9'b000000100 || b_adr !== 11'h000) begin
            err_cnt++;
            $display("FAIL rst_async_outputs: got %b adr %h expected 000000100 adr 000",
                     {b_busy, b_done, b_error, b_cyc, b_stb, b_we, b_sel, b_cfg_data, b_cfg_shift}, b_adr);
        end
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 b_start = 1'b1;
        @(posedge clk); #1 b_start = 1'b0;
        @(negedge clk);
        vec_cnt++;
        if (b_stb !== 1'b1 || b_adr !== 11'h020) begin
            err_cnt++; $display("FAIL rst_restart_addr: got stb %b adr %h expected 1 020", b_stb, b_adr);
        end
        cnt = 0; first = '0; fin = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (b_cfg_shift && cnt < 8) begin first = {first[6:0], b_cfg_data}; cnt++; end
            if (!b_busy) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        vec_cnt++;
        if (!fin || first !== 8'h11 || {b_done, b_error} !== 2'b10) begin
            err_cnt++; $display("FAIL rst_restart_load: got byte %h status %b expected 11 10", first, {b_done, b_error});
        end
    endtask

`ifdef EFUSE_CFG_LOADER_CRC_EN
    task automatic test_crc();
        mem[11'h010] = 8'h01; mem[11'h011] = 8'h02; mem[11'h012] = 8'h1B;
        run_a(100, 1'b0);
        vec_cnt++;
        if (obs_timeout || {obs_done, obs_error} !== 2'b10) begin
            err_cnt++; $display("FAIL crc_good: got %b expected 10", {obs_done, obs_error});
        end
        mem[11'h012] = 8'h00;
        run_a(100, 1'b0);
        vec_cnt++;
        if (obs_timeout || {obs_done, obs_error} !== 2'b01) begin
            err_cnt++; $display("FAIL crc_bad: got %b expected 01", {obs_done, obs_error});
        end
        vec_cnt++;
        if (bits16() !== 16'h0102) begin err_cnt++; $display("FAIL crc_bad_bits: got %h expected 0102", bits16()); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        a_start = 1'b0; a_ready = 1'b1; a_delay = 0; a_noack = 1'b0;
        b_start = 1'b0; b_ready = 1'b1;
        test_reset();
        test_basic();
        test_ack_delay();
        test_ack_at_timeout();
        test_timeout();
        test_ready_stall();
        test_reset_midshift();
`ifdef EFUSE_CFG_LOADER_CRC_EN
        test_crc();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish within 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
